alu_serial_ctrl: RTL and testbench
==================================

# alu_serial_ctrl

Bit-serial sequencer that drives the team's 1-bit `alu` slice to perform WIDTH-bit operations, one bit per clock, LSB first. It sits between an issuing unit (start/op/operands handshake) and a single shared `alu` slice. It owns the operand shift registers, the carry flop, the bit counter and the two-pass set-less-than sequence.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥2)

Ports:
- clk_i  in  1  clock; all registers on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  request; sampled only in IDLE
- op_i  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 SLT (signed); 110/111 invalid
- a_i  in  WIDTH  operand A, latched at accept
- b_i  in  WIDTH  operand B, latched at accept
- busy_o  out  1  high from the cycle after accept through the done cycle
- done_o  out  1  one-cycle completion pulse
- res_o  out  WIDTH  result; updated only on the done cycle, held otherwise
- cout_o  out  1  final carry (ADD/SUB), else 0
- ovf_o  out  1  signed overflow (ADD/SUB), else 0
- alu_a_o  out  1  slice A bit
- alu_b_o  out  1  slice B bit
- alu_c_o  out  1  slice carry-in (carry flop)
- alu_sel_o  out  4  slice select
- alu_inver_o  out  1  slice B-invert
- alu_set_o  out  1  slice set input
- alu_res_i  in  1  slice result bit (combinational from alu_* outputs)
- alu_co_i  in  1  slice carry-out

## Operation
- States: IDLE, RUN, SETP, DONE.
- IDLE: all alu_* outputs 0. If start_i=1: latch a_i, b_i, op_i; bit counter k=0; carry flop = 1 for SUB/SLT, else 0; go RUN. If start_i=0, stay.
- RUN (WIDTH cycles, k=0..WIDTH-1): alu_a_o=A[k], alu_b_o=B[k], alu_c_o=carry flop. Select: AND 0000, OR 0001, ADD/SUB/SLT 0010, XOR 0100, invalid 1111 (slice returns 0). alu_inver_o=1 for SUB/SLT. At each edge: result bit k ← alu_res_i, carry flop ← alu_co_i. On k=WIDTH-1, also capture carry-in to MSB (cin_msb) and MSB sum bit; then SLT → SETP with k=0, others → DONE.
- SETP (SLT only, WIDTH cycles): less = msb_sum XOR (cin_msb XOR final carry). alu_sel_o=0011, alu_set_o = less when k=0 else 0, alu_inver_o=0, alu_a_o/alu_b_o=0. Result bit k ← alu_res_i. After k=WIDTH-1 → DONE.
- DONE (1 cycle): done_o=1, busy_o=1; res_o ← assembled result; cout_o ← final carry and ovf_o ← cin_msb XOR final carry for ADD/SUB, else both 0. Next state IDLE. start_i ignored here.
- start_i while busy is ignored, not queued.
- Invalid op: full RUN pass, res_o=0, cout_o=0, ovf_o=0, normal done.

## Timing
- Accept at edge of cycle 0 (IDLE, start_i=1). RUN on cycles 1..WIDTH. Non-SLT: done_o on cycle WIDTH+1. SLT: SETP cycles WIDTH+1..2·WIDTH, done_o on cycle 2·WIDTH+1.
- res_o/cout_o/ovf_o change on the edge ending the DONE cycle.
- Back-to-back: earliest next accept is the cycle after DONE (IDLE).
- Reset (any time, including mid-RUN/SETP): immediately IDLE; busy_o, done_o, res_o, cout_o, ovf_o, all alu_* outputs, carry flop and counter = 0; no done pulse for the aborted op.
- Carry/bit counter wrap: counter never exceeds WIDTH-1; reload to 0 on RUN→SETP.

## Test plan
Bench instantiates the team's `alu` slice wired to alu_* ports, WIDTH=8.
- ADD 0xFF+0x01, start at cycle 0 -> done_o at cycle 9, res_o=0x00, cout_o=1, ovf_o=0; ADD 0x7F+0x01 -> 0x80, ovf_o=1.
- SUB 0x05-0x07 -> res_o=0xFE, cout_o=0, ovf_o=0; SUB 0x80-0x01 -> 0x7F, ovf_o=1.
- SLT 0x80 vs 0x01 -> res_o=0x01, done_o at cycle 17; SLT 0x01 vs 0x80 -> 0x00; SLT 0x7F vs 0x80 -> 0x00 (overflow-corrected).
- AND/OR/XOR 0xA5, 0x3C -> 0x24 / 0xBD / 0x99; cout_o=ovf_o=0; op 110 -> 0x00 with done at cycle 9.
- start_i held high through an ADD -> exactly one done_o, next accept on cycle 10; start_i pulses during busy ignored.
- rst_i asserted at cycle 4 of an ADD -> all outputs 0 asynchronously, no done_o; new op after release completes correctly.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving a 1-bit alu slice LSB first: WIDTH+1 cycles accept-to-done (2*WIDTH+1 for SLT).
// No backpressure: start_i is sampled only when idle; requests while busy are dropped, not queued.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             alu_a_o,
  output logic             alu_b_o,
  output logic             alu_c_o,
  output logic [3:0]       alu_sel_o,
  output logic             alu_inver_o,
  output logic             alu_set_o,
  input  logic             alu_res_i,
  input  logic             alu_co_i
);

  localparam int KW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, SETP, DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [KW-1:0]    k;
  logic             carry;
  logic             cin_msb;
  logic             msb_sum;
  logic             last;
  logic             is_sub;
  logic             less;

  assign last   = (k == KW'(WIDTH - 1));
  assign is_sub = (op_q == OP_SUB) || (op_q == OP_SLT);
  // After RUN the carry flop holds the final carry-out; SETP leaves it untouched.
  assign less   = msb_sum ^ cin_msb ^ carry;

  always_comb begin
    alu_a_o     = 1'b0;
    alu_b_o     = 1'b0;
    alu_c_o     = 1'b0;
    alu_sel_o   = 4'b0000;
    alu_inver_o = 1'b0;
    alu_set_o   = 1'b0;
    case (state)
      RUN: begin
        alu_a_o     = a_sh[0];
        alu_b_o     = b_sh[0];
        alu_c_o     = carry;
        alu_inver_o = is_sub;
        case (op_q)
          OP_AND:                 alu_sel_o = 4'b0000;
          OP_OR:                  alu_sel_o = 4'b0001;
          OP_ADD, OP_SUB, OP_SLT: alu_sel_o = 4'b0010;
          OP_XOR:                 alu_sel_o = 4'b0100;
          default:                alu_sel_o = 4'b1111;
        endcase
      end
      SETP: begin
        alu_sel_o = 4'b0011;
        alu_set_o = (k == '0) ? less : 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      op_q    <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      k       <= '0;
      carry   <= 1'b0;
      cin_msb <= 1'b0;
      msb_sum <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      res_o   <= '0;
      cout_o  <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            op_q   <= op_i;
            a_sh   <= a_i;
            b_sh   <= b_i;
            k      <= '0;
            carry  <= (op_i == OP_SUB) || (op_i == OP_SLT);
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= {alu_res_i, res_sh[WIDTH-1:1]};
          carry  <= alu_co_i;
          if (last) begin
            cin_msb <= carry;
            msb_sum <= alu_res_i;
            k       <= '0;
            if (op_q == OP_SLT) begin
              state <= SETP;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        SETP: begin
          res_sh <= {alu_res_i, res_sh[WIDTH-1:1]};
          if (last) begin
            k      <= '0;
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          res_o  <= res_sh;
          if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
            cout_o <= carry;
            ovf_o  <= cin_msb ^ carry;
          end else begin
            cout_o <= 1'b0;
            ovf_o  <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl with a behavioural 1-bit slice and an arithmetic reference model.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] res;
  logic         alu_a, alu_b, alu_c, alu_inver, alu_set, alu_res, alu_co;
  logic [3:0]   alu_sel;
  logic         bb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .res_o(res), .cout_o(cout), .ovf_o(ovf),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_c_o(alu_c), .alu_sel_o(alu_sel),
    .alu_inver_o(alu_inver), .alu_set_o(alu_set), .alu_res_i(alu_res), .alu_co_i(alu_co)
  );

  // 1-bit slice: select 0000 AND, 0001 OR, 0010 sum, 0011 set, 0100 XOR, others 0.
  always_comb begin
    bb     = alu_b ^ alu_inver;
    alu_co = (alu_a & bb) | (alu_a & alu_c) | (bb & alu_c);
    case (alu_sel)
      4'b0000: alu_res = alu_a & bb;
      4'b0001: alu_res = alu_a | bb;
      4'b0010: alu_res = alu_a ^ bb ^ alu_c;
      4'b0011: alu_res = alu_set;
      4'b0100: alu_res = alu_a ^ bb;
      default: alu_res = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0] s;
    r = '0; c = 1'b0; v = 1'b0;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd4: r = x ^ y;
      3'd2: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0]; c = s[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd3: begin
        s = {1'b0, x} + {1'b0, ~y} + 1;
        r = s[W-1:0]; c = s[W];
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd5: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      default: ;
    endcase
  endfunction

  // Waits up to 'limit' negedges for done; returns the cycle it appeared in, or -1.
  task automatic wait_done(input int limit, input bit noise, output int dc);
    dc = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (done) begin
        dc = c;
        if (noise) start = 1'b0;
        break;
      end
      if (noise) start = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit hold, input bit noise);
    logic [W-1:0] er;
    logic         ec, ev;
    int           dc;
    ref_model(o, x, y, er, ec, ev);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    @(negedge clk);
    check({tag, ".busy1"}, 32'(busy), 32'd1);
    wait_done(2 * W + 4, noise, dc);
    check({tag, ".done_cyc"}, 32'(dc + 1), (o == 3'd5) ? 32'(2 * W + 1) : 32'(W + 1));
    @(negedge clk);
    check({tag, ".res"}, 32'(res), 32'(er));
    check({tag, ".cout_ovf"}, {30'd0, cout, ovf}, {30'd0, ec, ev});
    check({tag, ".done_clr"}, 32'(done), 32'd0);
    if (hold) begin
      @(negedge clk);
      check({tag, ".reaccept"}, 32'(busy), 32'd1);
      start = 1'b0;
      wait_done(2 * W + 4, 1'b0, dc);
      check({tag, ".done2"}, 32'(dc > 0), 32'd1);
      @(negedge clk);
      check({tag, ".res2"}, 32'(res), 32'(er));
    end else begin
      check({tag, ".busy_clr"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #12;
    check("rst.outs", {busy, done, res, cout, ovf}, '0);
    check("rst.alu", {alu_a, alu_b, alu_c, alu_sel, alu_inver, alu_set}, '0);
    @(negedge clk);
    rst = 1'b0;

    do_op("add_ff_01", 3'd2, 8'hFF, 8'h01, 1'b0, 1'b0);
    do_op("add_7f_01", 3'd2, 8'h7F, 8'h01, 1'b0, 1'b0);
    do_op("sub_05_07", 3'd3, 8'h05, 8'h07, 1'b0, 1'b0);
    do_op("sub_80_01", 3'd3, 8'h80, 8'h01, 1'b0, 1'b0);
    do_op("slt_80_01", 3'd5, 8'h80, 8'h01, 1'b0, 1'b0);
    do_op("slt_01_80", 3'd5, 8'h01, 8'h80, 1'b0, 1'b0);
    do_op("slt_7f_80", 3'd5, 8'h7F, 8'h80, 1'b0, 1'b0);
    do_op("and", 3'd0, 8'hA5, 8'h3C, 1'b0, 1'b0);
    do_op("or",  3'd1, 8'hA5, 8'h3C, 1'b0, 1'b0);
    do_op("xor", 3'd4, 8'hA5, 8'h3C, 1'b0, 1'b0);
    do_op("inv110", 3'd6, 8'hA5, 8'h3C, 1'b0, 1'b0);
    do_op("hold_add", 3'd2, 8'h33, 8'h44, 1'b1, 1'b0);
    do_op("noise_sub", 3'd3, 8'h10, 8'h20, 1'b0, 1'b1);

    // Reset mid-run: outputs clear asynchronously and the aborted op never completes.
    do_op("pre_rst", 3'd2, 8'h7F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 8'h12; b = 8'h34;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst.outs", {busy, done, res, cout, ovf}, '0);
    check("midrst.alu", {alu_a, alu_b, alu_c, alu_sel, alu_inver, alu_set}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 2 * W; c++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("midrst.no_done", 32'(dcount), 32'd0);
    do_op("post_rst", 3'd2, 8'h12, 8'h34, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      do_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
            1'b0, (i % 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
